// File: rtl/cfi_ctrl_pkg.sv
// Shared types and defaults for the CFI violation scheduler.
package cfi_ctrl_pkg;

  localparam int unsigned CFI_NR_SRC_DEF     = 2;
  localparam int unsigned CFI_FIFO_DEPTH_DEF = 4;
  localparam int unsigned CFI_CNT_W_DEF      = 16;

  // Queue entries carry a fixed-width source field so the struct stays
  // independent of the source count (up to 256 checkers).
  localparam int unsigned CFI_SRC_MAX_W = 8;

  // RISC-V breakpoint exception code.
  localparam logic [63:0] CFI_CAUSE_BREAKPOINT = 64'd3;

  typedef struct packed {
    logic [CFI_SRC_MAX_W-1:0] src;
    logic [63:0]              tval;
  } cfi_viol_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2
  } sched_state_e;

endpackage

// File: rtl/cfi_viol_fifo.sv
// Synchronous FIFO of violation records with flush and same-cycle push+pop.
module cfi_viol_fifo
  import cfi_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = CFI_FIFO_DEPTH_DEF
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  cfi_viol_t data_i,
  input  logic      pop_i,
  output cfi_viol_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;
  cfi_viol_t     mem_q [DEPTH];

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];

  // Pointer/occupancy update; a full FIFO still accepts a push when it pops.
  always_comb begin
    pop_ok  = pop_i && !empty_o;
    push_ok = push_i && (!full_o || pop_ok);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage; contents are only visible through a non-empty head so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/cfi_violation_scheduler.sv
// Arbitrates CFI checker violations, queues them and presents one exception
// at a time to commit; keeps saturating per-source counters.
module cfi_violation_scheduler
  import cfi_ctrl_pkg::*;
#(
  parameter int unsigned NR_SRC     = CFI_NR_SRC_DEF,
  parameter int unsigned FIFO_DEPTH = CFI_FIFO_DEPTH_DEF,
  parameter int unsigned CNT_W      = CFI_CNT_W_DEF,
  parameter logic [63:0] CAUSE      = CFI_CAUSE_BREAKPOINT,
  localparam int unsigned SRC_W     = (NR_SRC > 1) ? $clog2(NR_SRC) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          cfg_en_i,
  input  logic                          cfg_trap_i,
  input  logic [NR_SRC-1:0]             viol_valid_i,
  input  logic [NR_SRC-1:0][63:0]       viol_tval_i,
  output logic                          ex_valid_o,
  output logic [63:0]                   ex_cause_o,
  output logic [63:0]                   ex_tval_o,
  output logic [SRC_W-1:0]              ex_src_o,
  input  logic                          ex_ack_i,
  input  logic                          cnt_clr_i,
  output logic [NR_SRC-1:0][CNT_W-1:0]  cnt_o,
  output logic                          overflow_o
);

  localparam logic [SRC_W:0] NR_SRC_L = (SRC_W+1)'(NR_SRC);

  logic [NR_SRC-1:0]            acc, q_pulse, cand;
  logic [NR_SRC-1:0]            pend_q, pend_d;
  logic [NR_SRC-1:0][63:0]      pend_tval_q, pend_tval_d;
  logic [SRC_W-1:0]             ptr_q, ptr_d, win;
  logic [SRC_W:0]               rr_sum, nxt_sum;
  logic                         arb_found, grant;
  logic                         ovf_q, ovf_d;
  logic [NR_SRC-1:0][CNT_W-1:0] cnt_q, cnt_d;
  sched_state_e                 state_q, state_d;
  logic                         vld_q, vld_d;
  logic [63:0]                  tval_q, tval_d;
  logic [SRC_W-1:0]             src_q, src_d;
  logic                         fifo_full, fifo_empty, fifo_pop;
  cfi_viol_t                    push_data, head;
  logic                         head_src_unused;

  assign head_src_unused = ^head.src;

  // Candidate set and round-robin pick starting at the pointer.
  always_comb begin
    acc       = viol_valid_i & {NR_SRC{cfg_en_i}};
    q_pulse   = (cfg_trap_i && !flush_i) ? acc : '0;
    cand      = q_pulse | pend_q;
    win       = '0;
    arb_found = 1'b0;
    rr_sum    = '0;
    for (int k = 0; k < NR_SRC; k++) begin
      rr_sum = {1'b0, ptr_q} + (SRC_W+1)'(k);
      if (rr_sum >= NR_SRC_L) rr_sum = rr_sum - NR_SRC_L;
      if (!arb_found && cand[rr_sum[SRC_W-1:0]]) begin
        arb_found = 1'b1;
        win       = rr_sum[SRC_W-1:0];
      end
    end
    // A head popped this cycle frees a slot for the winner.
    grant = arb_found && !flush_i && (!fifo_full || fifo_pop);
    // An already-pending source keeps its original PC; the new pulse is dropped.
    push_data.src  = CFI_SRC_MAX_W'(win);
    push_data.tval = pend_q[win] ? pend_tval_q[win] : viol_tval_i[win];
  end

  // Pending flags, overflow flag and round-robin pointer update.
  always_comb begin
    pend_d      = pend_q;
    pend_tval_d = pend_tval_q;
    ovf_d       = ovf_q;
    ptr_d       = ptr_q;
    nxt_sum     = {1'b0, win} + 1'b1;
    if (nxt_sum >= NR_SRC_L) nxt_sum = '0;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      for (int i = 0; i < NR_SRC; i++) begin
        if (q_pulse[i] && pend_q[i]) ovf_d = 1'b1;
        if (grant && (win == SRC_W'(i))) begin
          pend_d[i] = 1'b0;
        end else if (cand[i]) begin
          pend_d[i] = 1'b1;
          if (!pend_q[i]) pend_tval_d[i] = viol_tval_i[i];
        end
      end
    end
    if (grant) ptr_d = nxt_sum[SRC_W-1:0];
  end

  // Saturating counters; clear beats a same-cycle increment.
  always_comb begin
    for (int i = 0; i < NR_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr_i)                       cnt_d[i] = '0;
      else if (acc[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  // Arbiter, pending and counter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q      <= '0;
      pend_tval_q <= '0;
      ovf_q       <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_tval_q <= pend_tval_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  cfi_viol_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (grant),
    .data_i  (push_data),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Presentation FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: flush overrides everything, including a same-cycle ack.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (!fifo_empty) state_d = PRESENT;
        PRESENT: if (ex_ack_i)    state_d = HOLD;
        HOLD:                     state_d = IDLE;
        default:                  state_d = IDLE;
      endcase
    end
  end

  // Outputs: pop the head in IDLE and hold it stable while presented.
  always_comb begin
    fifo_pop = (state_q == IDLE) && !fifo_empty && !flush_i;
    vld_d    = (state_d == PRESENT);
    tval_d   = tval_q;
    src_d    = src_q;
    if (flush_i) begin
      tval_d = '0;
      src_d  = '0;
    end else if (fifo_pop) begin
      tval_d = head.tval;
      src_d  = head.src[SRC_W-1:0];
    end
  end

  // Registered exception outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      tval_q <= '0;
      src_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      tval_q <= tval_d;
      src_q  <= src_d;
    end
  end

  assign ex_valid_o = vld_q;
  assign ex_cause_o = vld_q ? CAUSE : '0;
  assign ex_tval_o  = tval_q;
  assign ex_src_o   = src_q;
  assign cnt_o      = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_cfi_violation_scheduler.sv
// Directed bench: counter table plus hand-written presentation sequences.
module tb_cfi_violation_scheduler;

  logic             clk = 1'b0, rst = 1'b1, flush = 1'b0, en = 1'b1, trap = 1'b1;
  logic             ack = 1'b0, clr = 1'b0;
  logic [1:0]       vv = '0;
  logic [1:0][63:0] vt = '0;

  logic             ex_valid, s_valid, ovf, s_ovf;
  logic [63:0]      ex_cause, ex_tval, s_cause, s_tval;
  logic [0:0]       ex_src, s_src;
  logic [1:0][15:0] cnt;
  logic [1:0][1:0]  s_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cfi_violation_scheduler #(.NR_SRC(2), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .cfg_en_i(en), .cfg_trap_i(trap),
    .viol_valid_i(vv), .viol_tval_i(vt), .ex_valid_o(ex_valid), .ex_cause_o(ex_cause),
    .ex_tval_o(ex_tval), .ex_src_o(ex_src), .ex_ack_i(ack), .cnt_clr_i(clr),
    .cnt_o(cnt), .overflow_o(ovf));

  // Narrow-counter instance for saturation checks; same stimulus.
  cfi_violation_scheduler #(.NR_SRC(2), .FIFO_DEPTH(4), .CNT_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .cfg_en_i(en), .cfg_trap_i(trap),
    .viol_valid_i(vv), .viol_tval_i(vt), .ex_valid_o(s_valid), .ex_cause_o(s_cause),
    .ex_tval_o(s_tval), .ex_src_o(s_src), .ex_ack_i(ack), .cnt_clr_i(clr),
    .cnt_o(s_cnt), .overflow_o(s_ovf));

  typedef struct {
    logic [1:0]  v;
    logic        en;
    logic        clr;
    logic [15:0] c0, c1;
    logic [1:0]  s0, s1;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] v, input logic [63:0] t0, input logic [63:0] t1);
    vv = v; vt[0] = t0; vt[1] = t1;
    step();
    vv = '0;
  endtask

  task automatic clear_cnt();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ex_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic present_ack(input string name, input logic [0:0] src, input logic [63:0] tval);
    bit ok;
    wait_valid(ok);
    chk({name, " seen"}, 64'(ok), 64'd1);
    if (ok) begin
      chk({name, " src"}, 64'(ex_src), 64'(src));
      chk({name, " tval"}, ex_tval, tval);
      chk({name, " cause"}, ex_cause, 64'd3);
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk({name, " hold"}, 64'(ex_valid), 64'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    bit ok;
    bit seen;

    //            v      en    clr   c0     c1     s0    s1
    tbl[0]  = '{2'b00, 1'b1, 1'b1, 16'd0, 16'd0, 2'd0, 2'd0};
    tbl[1]  = '{2'b10, 1'b1, 1'b0, 16'd0, 16'd1, 2'd0, 2'd1};
    tbl[2]  = '{2'b10, 1'b1, 1'b0, 16'd0, 16'd2, 2'd0, 2'd2};
    tbl[3]  = '{2'b10, 1'b1, 1'b0, 16'd0, 16'd3, 2'd0, 2'd3};
    tbl[4]  = '{2'b10, 1'b0, 1'b0, 16'd0, 16'd3, 2'd0, 2'd3};
    tbl[5]  = '{2'b01, 1'b1, 1'b0, 16'd1, 16'd3, 2'd1, 2'd3};
    tbl[6]  = '{2'b01, 1'b1, 1'b0, 16'd2, 16'd3, 2'd2, 2'd3};
    tbl[7]  = '{2'b01, 1'b1, 1'b0, 16'd3, 16'd3, 2'd3, 2'd3};
    tbl[8]  = '{2'b01, 1'b1, 1'b0, 16'd4, 16'd3, 2'd3, 2'd3};
    tbl[9]  = '{2'b01, 1'b1, 1'b0, 16'd5, 16'd3, 2'd3, 2'd3};
    tbl[10] = '{2'b01, 1'b1, 1'b1, 16'd0, 16'd0, 2'd0, 2'd0};
    tbl[11] = '{2'b11, 1'b1, 1'b0, 16'd1, 16'd1, 2'd1, 2'd1};
    tbl[12] = '{2'b11, 1'b0, 1'b0, 16'd1, 16'd1, 2'd1, 2'd1};

    // Reset state
    step();
    chk("reset valid", 64'(ex_valid), 64'd0);
    chk("reset cause", ex_cause, 64'd0);
    chk("reset tval", ex_tval, 64'd0);
    chk("reset src", 64'(ex_src), 64'd0);
    chk("reset ovf", 64'(ovf), 64'd0);
    chk("reset cnt0", 64'(cnt[0]), 64'd0);
    chk("reset cnt1", 64'(cnt[1]), 64'd0);
    rst = 1'b0;
    step();

    // Count-only mode: enable gating, saturation, clear priority
    trap = 1'b0;
    for (int i = 0; i < 13; i++) begin
      vv = tbl[i].v; vt[0] = 64'h100 + 64'(i); vt[1] = 64'h200 + 64'(i);
      en = tbl[i].en; clr = tbl[i].clr;
      step();
      vv = '0; en = 1'b1; clr = 1'b0;
      chk($sformatf("tbl%0d cnt0", i), 64'(cnt[0]), 64'(tbl[i].c0));
      chk($sformatf("tbl%0d cnt1", i), 64'(cnt[1]), 64'(tbl[i].c1));
      chk($sformatf("tbl%0d sat cnt0", i), 64'(s_cnt[0]), 64'(tbl[i].s0));
      chk($sformatf("tbl%0d sat cnt1", i), 64'(s_cnt[1]), 64'(tbl[i].s1));
      chk($sformatf("tbl%0d valid", i), 64'(ex_valid), 64'd0);
    end
    step();
    step();
    chk("count-only never presents", 64'(ex_valid), 64'd0);
    trap = 1'b1;

    // Single pulse latency: pulse in cycle N, valid in cycle N+2
    clear_cnt();
    pulse(2'b01, 64'h8000_0010, 64'h0);
    chk("t1 valid N+1", 64'(ex_valid), 64'd0);
    step();
    chk("t1 valid N+2", 64'(ex_valid), 64'd1);
    chk("t1 tval", ex_tval, 64'h8000_0010);
    chk("t1 src", 64'(ex_src), 64'd0);
    chk("t1 cause", ex_cause, 64'd3);
    chk("t1 cnt0", 64'(cnt[0]), 64'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t1 hold", 64'(ex_valid), 64'd0);
    chk("t1 cause off", ex_cause, 64'd0);
    step();
    chk("t1 idle", 64'(ex_valid), 64'd0);

    // Simultaneous pulses from a fresh round-robin pointer
    do_reset();
    pulse(2'b11, 64'hA000, 64'hB000);
    present_ack("t2 first", 1'b0, 64'hA000);
    step();
    chk("t2 gap", 64'(ex_valid), 64'd0);
    present_ack("t2 second", 1'b1, 64'hB000);
    chk("t2 cnt0", 64'(cnt[0]), 64'd1);
    chk("t2 cnt1", 64'(cnt[1]), 64'd1);

    // Fill the queue, leave one pending, then overflow it
    clear_cnt();
    for (int k = 0; k < 6; k++) begin
      vv = (k % 2 == 0) ? 2'b01 : 2'b10;
      vt[0] = 64'h1000 + 64'(k);
      vt[1] = 64'h1000 + 64'(k);
      step();
    end
    vv = 2'b10; vt[1] = 64'h2000;
    step();
    vv = '0;
    chk("t3 overflow", 64'(ovf), 64'd1);
    chk("t3 presenting", 64'(ex_valid), 64'd1);
    chk("t3 cnt0", 64'(cnt[0]), 64'd3);
    chk("t3 cnt1", 64'(cnt[1]), 64'd4);
    for (int k = 0; k < 6; k++)
      present_ack($sformatf("t3 drain%0d", k), 1'(k % 2), 64'h1000 + 64'(k));
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ex_valid) seen = 1'b1;
    end
    chk("t3 dropped not queued", 64'(seen), 64'd0);
    chk("t3 overflow sticky", 64'(ovf), 64'd1);

    // Flush during presentation with ack and a pulse in the same cycle
    clear_cnt();
    pulse(2'b11, 64'hC000, 64'hD000);
    wait_valid(ok);
    chk("t5 seen", 64'(ok), 64'd1);
    chk("t5 tval", ex_tval, 64'hC000);
    flush = 1'b1; ack = 1'b1; vv = 2'b01; vt[0] = 64'hE000;
    step();
    flush = 1'b0; ack = 1'b0; vv = '0;
    chk("t5 valid off", 64'(ex_valid), 64'd0);
    chk("t5 tval cleared", ex_tval, 64'd0);
    chk("t5 cause off", ex_cause, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ex_valid) seen = 1'b1;
    end
    chk("t5 queue empty", 64'(seen), 64'd0);
    chk("t5 cnt0", 64'(cnt[0]), 64'd2);
    chk("t5 cnt1", 64'(cnt[1]), 64'd1);
    chk("t5 overflow kept", 64'(ovf), 64'd1);

    // Asynchronous reset mid-presentation
    pulse(2'b01, 64'hF000, 64'h0);
    wait_valid(ok);
    chk("t7 seen", 64'(ok), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7 async valid", 64'(ex_valid), 64'd0);
    chk("t7 async ovf", 64'(ovf), 64'd0);
    chk("t7 async cnt0", 64'(cnt[0]), 64'd0);
    chk("t7 async tval", ex_tval, 64'd0);
    step();
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (ex_valid) seen = 1'b1;
    end
    chk("t7 nothing survives", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
